// File: rtl/aes256_pkg.sv
// ============================================================================
//  aes256_pkg : shared AES-256 constants, word type and key-schedule states
//  Rev 1.0
// ============================================================================
`default_nettype none

package aes256_pkg;

    localparam int NR     = 14;
    localparam int NK     = 8;
    localparam int NWORDS = 4 * (NR + 1);

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Indexed by i/8; entry 0 is never used by AES-256.
    localparam logic [7:0] RCON [8] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40
    };

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes256_key_expansion_if.sv
// ============================================================================
//  aes256_key_expansion_if : controller <-> key schedule signal bundle
//  Optional key_clear_i under AES_KEYEXP_ZEROIZE_EN.  Rev 1.0
// ============================================================================
`default_nettype none

interface aes256_key_expansion_if;

    logic         start_i;
    logic [255:0] key_i;
    logic [3:0]   round_num_i;
    logic [127:0] round_key_o;
    logic         busy_o;
    logic         done_o;
`ifdef AES_KEYEXP_ZEROIZE_EN
    logic         key_clear_i;
`endif

    modport master (
        output start_i, key_i, round_num_i,
`ifdef AES_KEYEXP_ZEROIZE_EN
        output key_clear_i,
`endif
        input  round_key_o, busy_o, done_o
    );

    modport slave (
        input  start_i, key_i, round_num_i,
`ifdef AES_KEYEXP_ZEROIZE_EN
        input  key_clear_i,
`endif
        output round_key_o, busy_o, done_o
    );

endinterface

`default_nettype wire

// File: rtl/aes_sbox_word.sv
// ============================================================================
//  aes_sbox_word : four parallel forward AES S-box lookups (combinational)
//  Rev 1.0
// ============================================================================
`default_nettype none

module aes_sbox_word
    import aes256_pkg::*;
(
    input  word_t word_i,
    output word_t word_o
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    generate
        for (genvar b = 0; b < 4; b++) begin : g_byte
            assign word_o[8*b +: 8] = SBOX[word_i[8*b +: 8]];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/aes256_key_expansion.sv
// ============================================================================
//  aes256_key_expansion : iterative AES-256 key schedule, one word per clock,
//  15 round keys served combinationally. Option: AES_KEYEXP_ZEROIZE_EN. Rev 1.0
// ============================================================================
`default_nettype none

module aes256_key_expansion #(
    parameter int NR = 14
) (
    input  wire                     clk,
    input  wire                     rst_n,
    aes256_key_expansion_if.slave   kx
);

    import aes256_pkg::*;

    localparam logic [5:0] LAST_IDX = 6'(4 * (NR + 1) - 1);

    state_t     state_q;
    logic [5:0] idx_q;
    logic       busy_q;
    logic       done_q;
    word_t      words_q [NWORDS];

    word_t      w_prev;
    word_t      w_back;
    word_t      w_sub_in;
    word_t      w_sub_out;
    word_t      w_temp;
    word_t      next_word_d;
    logic [5:0] w_rk_base;

    // Next schedule word w[i] from w[i-1] and w[i-8]
    always_comb begin
        w_prev   = words_q[idx_q - 6'd1];
        w_back   = words_q[idx_q - 6'd8];
        w_sub_in = (idx_q[2:0] == 3'd0) ? rot_word(w_prev) : w_prev;
        case (idx_q[2:0])
            3'd0:    w_temp = w_sub_out ^ {RCON[idx_q[5:3]], 24'h000000};
            3'd4:    w_temp = w_sub_out;
            default: w_temp = w_prev;
        endcase
        next_word_d = w_back ^ w_temp;
    end

    aes_sbox_word u_sbox (
        .word_i (w_sub_in),
        .word_o (w_sub_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int k = 0; k < NWORDS; k++) words_q[k] <= '0;
        end else begin
`ifdef AES_KEYEXP_ZEROIZE_EN
            if (kx.key_clear_i) begin
                state_q <= ST_IDLE;
                idx_q   <= '0;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
                for (int k = 0; k < NWORDS; k++) words_q[k] <= '0;
            end else
`endif
            begin
                case (state_q)
                    ST_IDLE, ST_DONE: begin
                        if (kx.start_i) begin
                            for (int k = 0; k < NK; k++) begin
                                words_q[k] <= kx.key_i[255 - 32*k -: 32];
                            end
                            idx_q   <= 6'd8;
                            state_q <= ST_EXPAND;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end
                    ST_EXPAND: begin
                        words_q[idx_q] <= next_word_d;
                        // Index parks on the last word rather than wrapping
                        if (idx_q == LAST_IDX) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 6'd1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        w_rk_base      = {kx.round_num_i, 2'b00};
        kx.round_key_o = '0;
        if (kx.round_num_i != 4'd15) begin
            kx.round_key_o = {words_q[w_rk_base],         words_q[w_rk_base + 6'd1],
                              words_q[w_rk_base + 6'd2],  words_q[w_rk_base + 6'd3]};
        end
    end

    assign kx.busy_o = busy_q;
    assign kx.done_o = done_q;

endmodule

`default_nettype wire

// File: tb/tb_aes256_key_expansion.sv
// ============================================================================
//  tb_aes256_key_expansion : scoreboard bench with an arithmetic AES model
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_aes256_key_expansion;

    typedef struct packed {
        logic          zero;
        logic [31:0]   accept;
        logic [3:0]    k0_r;
        logic [127:0]  k0_v;
        logic [3:0]    k1_r;
        logic [127:0]  k1_v;
        logic [1919:0] rk;
    } item_t;

    logic  clk;
    logic  rst_n;
    int    cyc;
    int    n_checks;
    int    n_errors;
    int    busy_cnt;
    item_t exp_q [$];

    aes256_key_expansion_if kif ();

    aes256_key_expansion #(.NR(14)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kx    (kif.slave)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model (FIPS-197 arithmetic) ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic       hi;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b  = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] s;
        inv = 8'h01;
        repeat (254) inv = gmul(inv, x);
        s = 8'h63 ^ inv;
        for (int n = 1; n <= 4; n++) s = s ^ ((inv << n) | (inv >> (8 - n)));
        return s;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [1919:0] model(input logic [255:0] key);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rcon;
        logic [1919:0] out;
        rcon = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = rcon << 1;
            end else if (i % 8 == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++)
            out[1919 - 128*r -: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return out;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        item_t it;
        logic [127:0] e;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                it = exp_q[0];
                if (it.zero) begin
                    check("reset busy_o", {127'd0, kif.busy_o}, 128'd0);
                    check("reset done_o", {127'd0, kif.done_o}, 128'd0);
                    for (int r = 0; r < 16; r++) begin
                        kif.round_num_i = 4'(r);
                        #1;
                        check($sformatf("cleared round %0d", r), kif.round_key_o, 128'd0);
                    end
                    void'(exp_q.pop_front());
                end else if (kif.done_o) begin
                    check("latency", 128'(cyc - int'(it.accept)), 128'd52);
                    check("busy cycles", 128'(busy_cnt), 128'd52);
                    check("busy_o in done", {127'd0, kif.busy_o}, 128'd0);
                    for (int r = 0; r < 16; r++) begin
                        kif.round_num_i = 4'(r);
                        #1;
                        e = (r == 15) ? 128'd0 : it.rk[1919 - 128*r -: 128];
                        check($sformatf("round %0d", r), kif.round_key_o, e);
                        if (4'(r) == it.k0_r) check($sformatf("kat round %0d", r), kif.round_key_o, it.k0_v);
                        if (4'(r) == it.k1_r) check($sformatf("kat round %0d", r), kif.round_key_o, it.k1_v);
                    end
                    busy_cnt = 0;
                    void'(exp_q.pop_front());
                end else begin
                    if (kif.busy_o) busy_cnt++;
                    if (cyc - int'(it.accept) > 70) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL done timeout: actual done_o=0 required done_o=1 after 52 cycles");
                        busy_cnt = 0;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic push_zero();
        item_t it;
        it      = '0;
        it.zero = 1'b1;
        exp_q.push_back(it);
    endtask

    task automatic do_start(input logic [255:0] k, input bit push,
                            input logic [3:0] r0, input logic [127:0] v0,
                            input logic [3:0] r1, input logic [127:0] v1);
        item_t it;
        @(negedge clk);
        kif.start_i = 1'b1;
        kif.key_i   = k;
        @(posedge clk);
        #1;
        kif.start_i = 1'b0;
        kif.key_i   = rand256();
        if (push) begin
            it.zero   = 1'b0;
            it.accept = 32'(cyc);
            it.k0_r   = r0;
            it.k0_v   = v0;
            it.k1_r   = r1;
            it.k1_v   = v1;
            it.rk     = model(k);
            exp_q.push_back(it);
        end
    endtask

    task automatic wait_empty();
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard drain: actual %0d pending required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    localparam logic [255:0] KEY_A3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        rst_n           = 1'b0;
        kif.start_i     = 1'b0;
        kif.key_i       = '0;
        kif.round_num_i = '0;
`ifdef AES_KEYEXP_ZEROIZE_EN
        kif.key_clear_i = 1'b0;
`endif
        push_zero();
        wait_empty();
        @(negedge clk);
        rst_n = 1'b1;
        push_zero();
        wait_empty();

        do_start(KEY_A3, 1'b1, 4'd2, 128'h9ba354118e6925afa51a8b5f2067fcde,
                 4'd14, 128'hfe4890d1e6188d0b046df344706c631e);
        wait_empty();

        // restart directly from DONE
        do_start(KEY_C3, 1'b1, 4'd0, 128'h000102030405060708090a0b0c0d0e0f,
                 4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        wait_empty();

        // a second start during expansion must be ignored
        do_start(KEY_A3, 1'b1, 4'd1, 128'h1f352c073b6108d72d9810a30914dff4,
                 4'd14, 128'hfe4890d1e6188d0b046df344706c631e);
        repeat (20) @(negedge clk);
        kif.start_i = 1'b1;
        kif.key_i   = rand256();
        @(negedge clk);
        kif.start_i = 1'b0;
        wait_empty();

        for (int n = 0; n < 4; n++) begin
            do_start(rand256(), 1'b1, 4'd15, 128'd0, 4'd15, 128'd0);
            wait_empty();
        end

`ifdef AES_KEYEXP_ZEROIZE_EN
        @(negedge clk);
        kif.key_clear_i = 1'b1;
        kif.start_i     = 1'b1;
        kif.key_i       = rand256();
        @(posedge clk);
        #1;
        kif.key_clear_i = 1'b0;
        kif.start_i     = 1'b0;
        push_zero();
        wait_empty();
`endif

        // asynchronous reset in the middle of an expansion
        do_start(rand256(), 1'b0, 4'd15, 128'd0, 4'd15, 128'd0);
        repeat (30) @(negedge clk);
        #2;
        rst_n = 1'b0;
        push_zero();
        wait_empty();
        @(negedge clk);
        rst_n = 1'b1;
        push_zero();
        wait_empty();

        do_start(rand256(), 1'b1, 4'd15, 128'd0, 4'd15, 128'd0);
        wait_empty();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/aes256_key_expansion.md
Name: aes256_key_expansion

Overview:
Iterative AES-256 key schedule. It sits directly upstream of the round controller and datapath.
- Takes a 256-bit cipher key and generates all 60 schedule words (w[0..59]), one word per clock.
- Stores them as 15 round keys.
- Raises done_o, which drives the controller's key_exp_done_i.
- Serves any round key combinationally, selected by the controller's round number.

Parameters:
- NR, 14, number of rounds; the schedule length is 4*(NR+1)=60 words. Fixed; only 14 is supported.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- start_i  in  1  start expansion; sampled when state is IDLE or DONE
- key_i  in  256  cipher key; key_i[255:224]=w[0] … key_i[31:0]=w[7]
- round_num_i  in  4  round-key index 0..14
- round_key_o  out  128  {w[4r],w[4r+1],w[4r+2],w[4r+3]}, with w[4r] in bits [127:96]
- busy_o  out  1  expansion in progress
- done_o  out  1  schedule complete and stable
- key_clear_i  in  1  zeroize request (present only with the optional feature)

Behaviour:
- Reset is asynchronous, active-low, on rst_n; the clock is clk. Reset gives:
  - state=IDLE, busy_o=0, done_o=0
  - word index=0
  - all 60 storage words = 0, so round_key_o=0
- States: IDLE, EXPAND, DONE.
- IDLE: if start_i=1 at an edge:
  - write key_i into w[0..7]
  - set index i=8, go to EXPAND
- EXPAND: each edge computes and writes w[i], then i<=i+1.
  - w[i] = w[i-8] ^ t.
  - If i%8==0: t = SubWord(RotWord(w[i-1])) ^ {Rcon[i/8],24'h0}.
  - If i%8==4: t = SubWord(w[i-1]).
  - Otherwise: t = w[i-1].
  - RotWord: {b0,b1,b2,b3} -> {b1,b2,b3,b0}.
  - Rcon[1..7] = 01,02,04,08,10,20,40.
  - After writing w[59], go to DONE.
- DONE: done_o=1 until a new start or reset. start_i=1 in DONE restarts exactly as from IDLE; done_o falls on that edge.
- Outputs:
  - busy_o=1 exactly while in EXPAND.
  - done_o=1 exactly while in DONE; it is registered state, not a pulse.
- Latency: from the start-accept edge E0, w[8..59] are written on E1..E52. done_o is 1 after E52, i.e. 52 cycles.
- start_i while in EXPAND is ignored and key_i is not re-sampled. key_i only needs to be stable at the accept edge.
- round_num_i and round_key_o:
  - round_key_o is combinational from round_num_i with zero-cycle latency.
  - For round_num_i 15, round_key_o=0.
  - The value is defined only while done_o=1. During EXPAND, partially written contents are visible and must not be used.
- Index width is 6 bits; the index never exceeds 59 and never wraps.
- Reset mid-EXPAND: immediate return to the reset values; no partial schedule is retained.

Optional Feature:
AES_KEYEXP_ZEROIZE_EN
- Enabled:
  - The key_clear_i port exists.
  - key_clear_i=1 at an edge, in any state, clears all 60 words to 0, goes to IDLE, and drops busy_o and done_o.
  - key_clear_i has priority over start_i on the same edge.
- Disabled: the port is absent and key material is cleared only by rst_n.

Decomposition:
- Shared package aes256_pkg:
  - NR=14, NK=8, NWORDS=60
  - Rcon constant table
  - 32-bit word typedef
  - state encoding typedef (IDLE/EXPAND/DONE)
- One sub-module, aes_sbox_word: four parallel forward S-box byte lookups, purely combinational. It is reusable by the round datapath's SubBytes.

Test Plan:
- FIPS-197 A.3 schedule: key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, pulse start_i.
  - Expect busy_o=1 for 52 cycles, then done_o=1.
  - round 1 = 1f352c073b6108d72d9810a30914dff4
  - round 2 = 9ba354118e6925afa51a8b5f2067fcde
  - round 14 = fe4890d1e6188d0b046df344706c631e
- FIPS-197 C.3 schedule: key 000102…1f. Expect round 0 = 000102030405060708090a0b0c0d0e0f and round 14 = 24fc79ccbf0979e9371ac23c6d68de36.
- Start ignored during EXPAND: pulse start_i with a different key at cycle 20 of expansion. Expect done_o still at cycle 52 and round 14 equal to the first key's value.
- Restart from DONE: after the A.3 test, start with the C.3 key.
  - done_o=0 the next cycle and busy_o=1.
  - done_o=1 52 cycles later with the C.3 round 14 value.
- Reset mid-EXPAND: assert rst_n=0 at cycle 30. Expect busy_o=0, done_o=0 and round_key_o=0 for all round_num_i; round_num_i=15 gives 0 at any time.
- Zeroize (with AES_KEYEXP_ZEROIZE_EN): in DONE, assert key_clear_i and start_i together. Expect IDLE, done_o=0 and all round keys=0.
